// File: rtl/noc_pkg.sv
// Shared NoC router constants, port-index encoding and output scheduler state type.
package noc_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int CREDIT_W   = 3;
    localparam int CREDIT_MAX = 4;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        SOUTH = 3'd1,
        WEST  = 3'd2,
        EAST  = 3'd3,
        NORTH = 3'd4
    } port_idx_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or below rr_ptr, wrapping
// from 0 back to NUM_PORTS-1.
module rr_priority_picker #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     index
);

    always_comb begin
        int         pos;
        logic       found;
        logic [IDX_W-1:0] sel;
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = int'(rr_ptr) - k;
            if (pos < 0) pos = pos + NUM_PORTS;
            sel = IDX_W'(pos);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                index      = sel;
            end
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Wormhole output-port scheduler: round-robin grant per packet, credit-based
// flow control toward the downstream buffer.
//
//   state  | meaning
//   IDLE   | no owner; grant the next requester when a credit is available
//   LOCKED | grant_o owner streams its packet until the tail flit is sent
module output_port_scheduler #(
    parameter int NUM_PORTS  = noc_pkg::NUM_PORTS,
    parameter int CREDIT_MAX = noc_pkg::CREDIT_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          valid_i,
    input  logic [NUM_PORTS-1:0]          tail_i,
    input  logic                          credit_up_i,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic                          send_o,
    output logic [noc_pkg::CREDIT_W-1:0]  credit_o,
    output logic                          busy_o,
    output logic                          err_o
);
    import noc_pkg::*;

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_PORTS - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

    sched_state_e         state_q, state_d;
    logic [NUM_PORTS-1:0] grant_d, pick_grant;
    logic [IDX_W-1:0]     rr_q, rr_d, owner_q, owner_d, pick_idx;
    logic                 tail_hit;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req_i),
        .rr_ptr (rr_q),
        .grant  (pick_grant),
        .index  (pick_idx)
    );

    assign busy_o   = (state_q == LOCKED);
    assign send_o   = busy_o & (|(grant_o & valid_i)) & (credit_o != '0);
    assign tail_hit = |(grant_o & tail_i);

    always_comb begin
        state_d = state_q;
        grant_d = grant_o;
        rr_d    = rr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                // Grant decision uses the registered credit count only.
                if ((|req_i) && (credit_o != '0)) begin
                    state_d = LOCKED;
                    grant_d = pick_grant;
                    owner_d = pick_idx;
                end
            end
            LOCKED: begin
                if (send_o && tail_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = (owner_q == '0) ? LAST_IDX : owner_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_o <= '0;
            rr_q    <= LAST_IDX;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_o <= grant_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    // A credit return into a full counter is a protocol error; the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_o <= CREDIT_FULL;
            err_o    <= 1'b0;
        end else if (credit_up_i && !send_o) begin
            if (credit_o == CREDIT_FULL) err_o    <= 1'b1;
            else                         credit_o <= credit_o + 1'b1;
        end else if (!credit_up_i && send_o) begin
            credit_o <= credit_o - 1'b1;
        end
    end

endmodule

// File: doc/output_port_scheduler.md
OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, number of input ports competing for this output (bit 4 north, 3 east, 2 west, 1 south, 0 local).
REQ-002 SHALL have parameter CREDIT_MAX, default 4, downstream buffer depth in flits, and the credit reset value.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_i, input, NUM_PORTS, input i holds a head flit routed to this output.
REQ-006 SHALL have port valid_i, input, NUM_PORTS, input i holds a flit (head or body) ready to send.
REQ-007 SHALL have port tail_i, input, NUM_PORTS, the flit at input i is the last flit of its packet.
REQ-008 SHALL have port credit_up_i, input, 1, downstream consumed one flit (credit return).
REQ-009 SHALL have port grant_o, output, NUM_PORTS, registered one-hot grant, all-zero when idle.
REQ-010 SHALL have port send_o, output, 1, the granted input's flit crosses this output this cycle.
REQ-011 SHALL have port credit_o, output, 3, current free downstream slots.
REQ-012 SHALL have port busy_o, output, 1, high while in LOCKED.
REQ-013 SHALL have port err_o, output, 1, sticky credit overflow/underflow flag.

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED.
REQ-015 In IDLE, when req_i != 0 and credit_o > 0, SHALL select the first requester at or after rr_ptr in descending-wrap order (rr_ptr, rr_ptr-1, ..., 0, NUM_PORTS-1, ...), set grant_o to that one-hot and enter LOCKED on the next edge (1-cycle request-to-grant latency).
REQ-016 In IDLE with credit_o == 0, SHALL issue no grant regardless of req_i.
REQ-017 SHALL drive send_o combinationally: send_o = busy_o & |(grant_o & valid_i) & (credit_o != 0); always 0 in IDLE.
REQ-018 In LOCKED, SHALL hold grant_o unchanged regardless of req_i from other inputs (wormhole lock).
REQ-019 When send_o and the granted tail_i are both high, SHALL return to IDLE on the next edge, clear grant_o and set rr_ptr to the granted index minus 1, wrapping 0 to NUM_PORTS-1.
REQ-020 A single-flit packet (head with tail_i high) SHALL lock for exactly one send cycle.
REQ-021 SHALL update credit_o as credit_o + credit_up_i - send_o; simultaneous up and send SHALL leave it unchanged.
REQ-022 credit_up_i with credit_o == CREDIT_MAX and no send SHALL hold credit_o at CREDIT_MAX and set err_o.
REQ-023 Valid-but-unsent cycles (valid low or credit 0) SHALL stall in LOCKED without releasing the grant.
REQ-024 In IDLE, the next grant SHALL be evaluated in the same cycle as credit_up_i raises credit from 0 only on the following cycle (grant uses the registered credit_o).

Reset
REQ-025 While rst is high at a clock edge, state SHALL become IDLE, grant_o 0, send_o 0, busy_o 0, err_o 0, credit_o CREDIT_MAX, rr_ptr NUM_PORTS-1 (north first).
REQ-026 Reset asserted mid-packet SHALL abandon the lock and restore full credit; no partial state survives.

Structure
REQ-027 SHALL place NUM_PORTS, CREDIT_W (3), CREDIT_MAX and the port-index enum (NORTH=4, EAST=3, WEST=2, SOUTH=1, LOCAL=0) in shared package noc_pkg.
REQ-028 SHALL implement selection in one combinational sub-module rr_priority_picker (inputs req vector and rr_ptr, output one-hot grant and index).
REQ-029 SHALL contain no other sub-modules; credit counter and FSM live in this module.

Verification
REQ-030 Reset, then req_i=5'b10100 at cycle 1 -> grant_o=5'b10000 at cycle 2, busy_o=1, credit_o=4.
REQ-031 North 3-flit packet, valid_i held, tail on flit 3, no credit_up -> send_o high 3 cycles, credit_o 4->1, grant released; then still-pending west req -> grant_o=5'b00100 next cycle.
REQ-032 Credit exhaustion: 5-flit packet, no credit_up -> 4 sends, send_o low with credit_o=0 and grant held; one credit_up_i -> credit_o=1, send resumes next cycle.
REQ-033 Fairness: all five req_i high continuously with single-flit packets -> grant order north, east, west, south, local, north.
REQ-034 credit_up_i pulse at credit_o=4 with idle output -> credit_o stays 4, err_o=1 until rst.
REQ-035 rst pulsed during LOCKED after 2 sends -> next cycle grant_o=0, credit_o=4, busy_o=0, err_o=0.
